// File: rtl/deconv_col_engine_pkg.sv
// Shared sizing helpers for the column deconvolution engine: derived
// output length, weight FIFO depth and output pixel slicing.
package deconv_col_engine_pkg;

    // Output pixels are products of two BIT_WIDTH operands.
    localparam int PROD_SCALE = 2;

    function automatic int calc_n_pix_out(input int feature_size, input int stride, input int weight_size);
        return (feature_size - 1) * stride + weight_size;
    endfunction

    function automatic int calc_depth(input int weight_size);
        return weight_size * weight_size;
    endfunction

    function automatic int pix_lsb(input int pix, input int bit_width);
        return pix * PROD_SCALE * bit_width;
    endfunction

endpackage

// File: rtl/weight_col_fifo.sv
// Circular weight buffer that exports K entries at a time into a column
// register, with loop-back replay and flush.
module weight_col_fifo
    import deconv_col_engine_pkg::*;
#(
    parameter int WEIGHT_SIZE = 5,
    parameter int BIT_WIDTH   = 8
) (
    input  logic                             i_clk,
    input  logic                             i_rst_n,
    input  logic                             i_w_wr_en,
    input  logic [BIT_WIDTH-1:0]             i_w_data,
    input  logic                             i_w_flush,
    input  logic                             i_w_loop,
    input  logic                             i_next_wcol,
    output logic                             o_w_full,
    output logic                             o_w_empty,
    output logic                             o_w_col_valid,
    output logic                             o_w_export_done,
    output logic [BIT_WIDTH*WEIGHT_SIZE-1:0] o_weight_col
);

    localparam int DEPTH = calc_depth(WEIGHT_SIZE);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [BIT_WIDTH-1:0]             mem [DEPTH];
    logic [PTR_W-1:0]                 rd_ptr, wr_ptr, rd_ptr_next, wr_ptr_next;
    logic [CNT_W-1:0]                 count, count_next;
    logic                             col_valid, export_done;
    logic [BIT_WIDTH*WEIGHT_SIZE-1:0] weight_col, col_next;
    logic                             full, empty, wr_ok, do_export, starve;

    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base, input int ofs);
        int sum;
        sum = int'(base) + ofs;
        if (sum >= DEPTH) sum = sum - DEPTH;
        return sum[PTR_W-1:0];
    endfunction

    always_comb begin
        full        = (count == CNT_W'(DEPTH));
        empty       = (count == '0);
        wr_ok       = i_w_wr_en && !full && !i_w_loop;
        // Decisions use the registered count, so a same-cycle write never completes a column.
        do_export   = (count >= CNT_W'(WEIGHT_SIZE)) && (!col_valid || i_next_wcol);
        starve      = i_next_wcol && (count < CNT_W'(WEIGHT_SIZE));
        col_next    = '0;
        for (int k = 0; k < WEIGHT_SIZE; k++) begin
            col_next[k*BIT_WIDTH +: BIT_WIDTH] = mem[wrap_add(rd_ptr, k)];
        end
        rd_ptr_next = do_export ? wrap_add(rd_ptr, WEIGHT_SIZE) : rd_ptr;
        wr_ptr_next = wr_ok ? wrap_add(wr_ptr, 1) : wr_ptr;
        count_next  = count;
        if (wr_ok) count_next = count_next + CNT_W'(1);
        if (do_export && !i_w_loop) count_next = count_next - CNT_W'(WEIGHT_SIZE);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_w_flush) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            col_valid   <= 1'b0;
            export_done <= 1'b0;
            weight_col  <= '0;
        end else begin
            rd_ptr      <= rd_ptr_next;
            wr_ptr      <= wr_ptr_next;
            count       <= count_next;
            export_done <= do_export;
            if (do_export) begin
                weight_col <= col_next;
                col_valid  <= 1'b1;
            end else if (starve) begin
                col_valid  <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_ok && !i_w_flush) mem[wr_ptr] <= i_w_data;
    end

    assign o_w_full        = full;
    assign o_w_empty       = empty;
    assign o_w_col_valid   = col_valid;
    assign o_w_export_done = export_done;
    assign o_weight_col    = weight_col;

endmodule

// File: rtl/deconv_col_engine.sv
// Transposed-convolution column engine: one weight column times one feature
// column, overlap-added with stride into a registered output column.
module deconv_col_engine
    import deconv_col_engine_pkg::*;
#(
    parameter int  WEIGHT_SIZE    = 5,
    parameter int  BIT_WIDTH      = 8,
    parameter int  FEATURE_SIZE   = 8,
    parameter int  STRIDE_SETTING = 2,
    localparam int N_PIX_OUT      = calc_n_pix_out(FEATURE_SIZE, STRIDE_SETTING, WEIGHT_SIZE),
    localparam int PIX_W          = PROD_SCALE * BIT_WIDTH
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic                              i_w_wr_en,
    input  logic [BIT_WIDTH-1:0]              i_w_data,
    input  logic                              i_w_flush,
    input  logic                              i_w_loop,
    input  logic                              i_next_wcol,
    input  logic [BIT_WIDTH*FEATURE_SIZE-1:0] i_feature_map_col,
    input  logic                              i_enable_loadip,
    output logic                              o_w_full,
    output logic                              o_w_empty,
    output logic                              o_w_col_valid,
    output logic                              o_w_export_done,
    output logic [BIT_WIDTH*WEIGHT_SIZE-1:0]  o_weight_col,
    output logic [PIX_W*N_PIX_OUT-1:0]        o_cmpl_deconv_col,
    output logic                              o_valid
);

    logic                             col_valid;
    logic [BIT_WIDTH*WEIGHT_SIZE-1:0] weight_col;
    logic [PIX_W-1:0]                 acc [N_PIX_OUT];
    logic [PIX_W*N_PIX_OUT-1:0]       cmpl_p0, cmpl_p1;
    logic                             vld_p0, vld_p1;

    // Unsigned multiply-accumulate that deliberately wraps at PIX_W bits.
    function automatic logic [PIX_W-1:0] wrap_mac(input logic [PIX_W-1:0] sum,
                                                  input logic [BIT_WIDTH-1:0] f,
                                                  input logic [BIT_WIDTH-1:0] w);
        return sum + PIX_W'(f) * PIX_W'(w);
    endfunction

    weight_col_fifo #(
        .WEIGHT_SIZE (WEIGHT_SIZE),
        .BIT_WIDTH   (BIT_WIDTH)
    ) u_fifo (
        .i_clk           (i_clk),
        .i_rst_n         (i_rst_n),
        .i_w_wr_en       (i_w_wr_en),
        .i_w_data        (i_w_data),
        .i_w_flush       (i_w_flush),
        .i_w_loop        (i_w_loop),
        .i_next_wcol     (i_next_wcol),
        .o_w_full        (o_w_full),
        .o_w_empty       (o_w_empty),
        .o_w_col_valid   (col_valid),
        .o_w_export_done (o_w_export_done),
        .o_weight_col    (weight_col)
    );

    // Stage p0: scatter each f[i]*w[k] product onto output pixel i*S + k.
    always_comb begin
        for (int j = 0; j < N_PIX_OUT; j++) acc[j] = '0;
        for (int i = 0; i < FEATURE_SIZE; i++) begin
            for (int k = 0; k < WEIGHT_SIZE; k++) begin
                acc[i*STRIDE_SETTING + k] = wrap_mac(acc[i*STRIDE_SETTING + k],
                                                     i_feature_map_col[i*BIT_WIDTH +: BIT_WIDTH],
                                                     weight_col[k*BIT_WIDTH +: BIT_WIDTH]);
            end
        end
        cmpl_p0 = '0;
        for (int j = 0; j < N_PIX_OUT; j++) cmpl_p0[pix_lsb(j, BIT_WIDTH) +: PIX_W] = acc[j];
        vld_p0 = i_enable_loadip && col_valid;
    end

    // Stage p1: output column register, held until the next accepted compute.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            vld_p1  <= 1'b0;
            cmpl_p1 <= '0;
        end else begin
            vld_p1 <= vld_p0;
            if (vld_p0) cmpl_p1 <= cmpl_p0;
        end
    end

    assign o_w_col_valid     = col_valid;
    assign o_weight_col      = weight_col;
    assign o_cmpl_deconv_col = cmpl_p1;
    assign o_valid           = vld_p1;

endmodule

// File: tb/tb_deconv_col_engine.sv
// Self-checking bench for deconv_col_engine: directed scenarios plus random
// traffic, all compared against a behavioural model of the weight buffer.
module tb_deconv_col_engine;

    localparam int K = 5, BW = 8, F = 8, S = 2;
    localparam int NP = (F - 1) * S + K;
    localparam int DEPTH = K * K;

    typedef logic [511:0] val_t;

    logic clk = 1'b0;
    logic rst_n, w_wr_en, w_flush, w_loop, next_wcol, loadip;
    logic [BW-1:0] w_data;
    logic [BW*F-1:0] fmap;
    logic w_full, w_empty, w_col_valid, w_export_done, valid;
    logic [BW*K-1:0] weight_col;
    logic [2*BW*NP-1:0] cmpl;

    int n_checks = 0;
    int n_fail = 0;

    // Model state
    logic [BW-1:0] m_mem [DEPTH];
    int m_rptr, m_wptr, m_cnt;
    logic [BW-1:0] m_col [K];
    logic m_colv, m_done, m_vld;
    logic [2*BW-1:0] m_out [NP];

    logic [BW-1:0] written [32];

    always #5 clk = ~clk;

    deconv_col_engine #(.WEIGHT_SIZE(K), .BIT_WIDTH(BW), .FEATURE_SIZE(F), .STRIDE_SETTING(S)) dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_w_wr_en         (w_wr_en),
        .i_w_data          (w_data),
        .i_w_flush         (w_flush),
        .i_w_loop          (w_loop),
        .i_next_wcol       (next_wcol),
        .i_feature_map_col (fmap),
        .i_enable_loadip   (loadip),
        .o_w_full          (w_full),
        .o_w_empty         (w_empty),
        .o_w_col_valid     (w_col_valid),
        .o_w_export_done   (w_export_done),
        .o_weight_col      (weight_col),
        .o_cmpl_deconv_col (cmpl),
        .o_valid           (valid)
    );

    task automatic check(input string tag, input val_t got, input val_t exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Direct form: out[j] sums f[i]*w[j-i*S] over every i giving a valid kernel row.
    function automatic logic [2*BW-1:0] ref_pixel(input int j);
        int sum, k;
        sum = 0;
        for (int i = 0; i < F; i++) begin
            k = j - i * S;
            if (k >= 0 && k < K) sum += int'(fmap[i*BW +: BW]) * int'(m_col[k]);
        end
        return sum[2*BW-1:0];
    endfunction

    task automatic model_step();
        bit exp_now, wr_now, starve;
        if (!rst_n) begin
            m_rptr = 0; m_wptr = 0; m_cnt = 0;
            m_colv = 0; m_done = 0; m_vld = 0;
            for (int k = 0; k < K; k++) m_col[k] = '0;
            for (int j = 0; j < NP; j++) m_out[j] = '0;
            return;
        end
        m_vld = loadip && m_colv;
        if (m_vld) for (int j = 0; j < NP; j++) m_out[j] = ref_pixel(j);
        if (w_flush) begin
            m_rptr = 0; m_wptr = 0; m_cnt = 0; m_colv = 0; m_done = 0;
            for (int k = 0; k < K; k++) m_col[k] = '0;
            return;
        end
        exp_now = (m_cnt >= K) && (!m_colv || next_wcol);
        starve  = next_wcol && (m_cnt < K);
        wr_now  = w_wr_en && (m_cnt < DEPTH) && !w_loop;
        m_done  = exp_now;
        if (exp_now) begin
            for (int k = 0; k < K; k++) m_col[k] = m_mem[(m_rptr + k) % DEPTH];
            m_colv = 1;
            m_rptr = (m_rptr + K) % DEPTH;
            if (!w_loop) m_cnt -= K;
        end else if (starve) begin
            m_colv = 0;
        end
        if (wr_now) begin
            m_mem[m_wptr] = w_data;
            m_wptr = (m_wptr + 1) % DEPTH;
            m_cnt++;
        end
    endtask

    task automatic compare_all();
        logic [BW*K-1:0] ecol;
        logic [2*BW*NP-1:0] eout;
        for (int k = 0; k < K; k++) ecol[k*BW +: BW] = m_col[k];
        for (int j = 0; j < NP; j++) eout[j*2*BW +: 2*BW] = m_out[j];
        check("full",  val_t'(w_full),        val_t'(m_cnt == DEPTH));
        check("empty", val_t'(w_empty),       val_t'(m_cnt == 0));
        check("colv",  val_t'(w_col_valid),   val_t'(m_colv));
        check("done",  val_t'(w_export_done), val_t'(m_done));
        check("wcol",  val_t'(weight_col),    val_t'(ecol));
        check("valid", val_t'(valid),         val_t'(m_vld));
        check("out",   val_t'(cmpl),          val_t'(eout));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic idle();
        w_wr_en = 0; w_flush = 0; next_wcol = 0; loadip = 0;
    endtask

    task automatic write_word(input logic [BW-1:0] d);
        w_wr_en = 1; w_data = d;
        tick();
        w_wr_en = 0;
    endtask

    task automatic do_flush();
        idle(); w_flush = 1;
        tick();
        w_flush = 0;
    endtask

    initial begin
        int exp_tbl [NP];
        logic [BW*K-1:0] first_col, second_col;
        exp_tbl = '{1, 2, 4, 6, 9, 6, 9, 6, 9, 6, 9, 6, 9, 6, 9, 6, 8, 4, 5};
        rst_n = 0; w_data = '0; w_loop = 0; fmap = '0;
        idle();

        // Reset
        tick(); tick();
        check("rst_empty", val_t'(w_empty), val_t'(1'b1));
        check("rst_colv",  val_t'(w_col_valid), val_t'(1'b0));
        check("rst_valid", val_t'(valid), val_t'(1'b0));
        check("rst_out",   val_t'(cmpl), val_t'(0));
        rst_n = 1;
        tick();

        // Load 1..5 and compute with all-ones features
        for (int i = 1; i <= K; i++) write_word(BW'(i));
        tick();
        check("ld_done", val_t'(w_export_done), val_t'(1'b1));
        check("ld_wcol", val_t'(weight_col), val_t'(40'h05_04_03_02_01));
        fmap = {F{8'd1}}; loadip = 1;
        tick();
        loadip = 0;
        check("ld_valid", val_t'(valid), val_t'(1'b1));
        for (int j = 0; j < NP; j++) check("ld_pix", val_t'(cmpl[j*2*BW +: 2*BW]), val_t'(exp_tbl[j]));
        tick();
        check("ld_hold_valid", val_t'(valid), val_t'(1'b0));
        check("ld_hold_pix18", val_t'(cmpl[18*2*BW +: 2*BW]), val_t'(5));

        // Overflow wrap
        do_flush();
        for (int i = 0; i < K; i++) write_word(8'hFF);
        tick();
        fmap = {F{8'hFF}}; loadip = 1;
        tick();
        loadip = 0;
        check("ovf_pix0", val_t'(cmpl[0 +: 16]), val_t'(65025));
        check("ovf_pix4", val_t'(cmpl[4*16 +: 16]), val_t'(64003));

        // Loop mode: 25 weights, then replay
        do_flush();
        for (int i = 0; i < DEPTH; i++) begin
            written[i] = BW'($urandom);
            write_word(written[i]);
        end
        tick();
        for (int k = 0; k < K; k++) begin
            first_col[k*BW +: BW]  = written[k];
            second_col[k*BW +: BW] = written[K + k];
        end
        check("loop_col1", val_t'(weight_col), val_t'(first_col));
        w_loop = 1;
        for (int n = 1; n <= 6; n++) begin
            next_wcol = 1; fmap = {$urandom, $urandom}; loadip = 1;
            tick();
            next_wcol = 0; loadip = 0;
            check("loop_done", val_t'(w_export_done), val_t'(1'b1));
            tick();
            if (n == 5) check("loop_col6", val_t'(weight_col), val_t'(first_col));
            if (n == 6) check("loop_col7", val_t'(weight_col), val_t'(second_col));
        end
        check("loop_notfull", val_t'(w_full), val_t'(1'b0));
        w_data = 8'h5A; w_wr_en = 1;
        tick();
        w_wr_en = 0; w_loop = 0;

        // Full and flush
        do_flush();
        for (int i = 0; i < 31; i++) write_word(BW'($urandom));
        check("full_flag", val_t'(w_full), val_t'(1'b1));
        do_flush();
        check("flush_empty", val_t'(w_empty), val_t'(1'b1));
        check("flush_colv",  val_t'(w_col_valid), val_t'(1'b0));
        loadip = 1;
        tick();
        loadip = 0;
        check("flush_novalid", val_t'(valid), val_t'(1'b0));

        // Starvation
        for (int i = 0; i < 8; i++) write_word(BW'($urandom));
        check("starve_pre_colv", val_t'(w_col_valid), val_t'(1'b1));
        next_wcol = 1;
        tick();
        next_wcol = 0;
        check("starve_colv", val_t'(w_col_valid), val_t'(1'b0));
        write_word(BW'($urandom));
        write_word(BW'($urandom));
        check("starve_wait", val_t'(w_col_valid), val_t'(1'b0));
        tick();
        check("starve_refill", val_t'(w_col_valid), val_t'(1'b1));
        check("starve_done", val_t'(w_export_done), val_t'(1'b1));

        // Random traffic
        for (int c = 0; c < 600; c++) begin
            rst_n     = ($urandom_range(0, 299) != 0);
            w_wr_en   = $urandom_range(0, 1);
            w_data    = BW'($urandom);
            w_flush   = ($urandom_range(0, 39) == 0);
            w_loop    = ($urandom_range(0, 5) == 0);
            next_wcol = ($urandom_range(0, 3) == 0);
            loadip    = $urandom_range(0, 1);
            fmap      = {$urandom, $urandom};
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
